// File: rtl/nco_quadrant_mapper.sv
// NCO front end: phase accumulator, quadrant fold onto quarter-wave sine/cosine ROMs, sign rebuild.
// Two enabled edges from accumulator phase to registered sample; enable low freezes every stage.
module nco_quadrant_mapper #(
    parameter int PHASE_WIDTH = 32,
    parameter int QLUT_DEPTH  = 8,
    parameter int DATA_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [PHASE_WIDTH-1:0]       ftw_in,
    input  logic                         ftw_load,
    input  logic                         phase_clr,
    output logic [QLUT_DEPTH-3:0]        lut_sin_addr,
    input  logic signed [DATA_WIDTH-1:0] lut_sin_value,
    output logic [QLUT_DEPTH-3:0]        lut_cos_addr,
    input  logic signed [DATA_WIDTH-1:0] lut_cos_value,
    output logic signed [DATA_WIDTH-1:0] sin_out,
    output logic signed [DATA_WIDTH-1:0] cos_out,
    output logic                         out_valid
);

    localparam int FW = QLUT_DEPTH - 2;
    localparam logic [QLUT_DEPTH-1:0] QUARTER = {2'b01, {FW{1'b0}}};

    logic [PHASE_WIDTH-1:0] ftw;
    logic [PHASE_WIDTH-1:0] acc;
    logic [QLUT_DEPTH-1:0]  p;
    logic [QLUT_DEPTH-1:0]  p_cos;
    logic [1:0]             vld_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ftw <= '0;
        end else if (ftw_load) begin
            ftw <= ftw_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            p      <= '0;
            vld_sr <= '0;
        end else if (enable) begin
            acc    <= phase_clr ? '0 : acc + ftw;
            p      <= acc[PHASE_WIDTH-1 -: QLUT_DEPTH];
            vld_sr <= {vld_sr[0], 1'b1};
        end
    end

    // Cosine is the sine index advanced by one quadrant; odd quadrants read the ROM mirrored.
    assign p_cos        = p + QUARTER;
    assign lut_sin_addr = p[FW]     ? ~p[FW-1:0]     : p[FW-1:0];
    assign lut_cos_addr = p_cos[FW] ? ~p_cos[FW-1:0] : p_cos[FW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sin_out <= '0;
            cos_out <= '0;
        end else if (enable) begin
            sin_out <= p[QLUT_DEPTH-1]     ? -lut_sin_value : lut_sin_value;
            cos_out <= p_cos[QLUT_DEPTH-1] ? -lut_cos_value : lut_cos_value;
        end
    end

    assign out_valid = vld_sr[1];

endmodule

// File: tb/tb_nco_quadrant_mapper.sv
// Bench for nco_quadrant_mapper: quarter-wave ROM model plus full-period trigonometric reference.
module tb_nco_quadrant_mapper;

    localparam int PW = 32;
    localparam int QD = 8;
    localparam int DW = 12;
    localparam int NPTS = 1 << QD;
    localparam real PI = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic [PW-1:0]        ftw_in = '0;
    logic                 ftw_load = 1'b0;
    logic                 phase_clr = 1'b0;
    logic [QD-3:0]        lut_sin_addr;
    logic [QD-3:0]        lut_cos_addr;
    logic signed [DW-1:0] lut_sin_value;
    logic signed [DW-1:0] lut_cos_value;
    logic signed [DW-1:0] sin_out;
    logic signed [DW-1:0] cos_out;
    logic                 out_valid;

    logic signed [DW-1:0] rom [NPTS/4];

    int checks = 0;
    int failures = 0;

    // reference state
    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_ftw;
    int            m_p;
    int            m_vcnt;
    int            m_sin;
    int            m_cos;

    nco_quadrant_mapper #(.PHASE_WIDTH(PW), .QLUT_DEPTH(QD), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ftw_in(ftw_in),
        .ftw_load(ftw_load), .phase_clr(phase_clr),
        .lut_sin_addr(lut_sin_addr), .lut_sin_value(lut_sin_value),
        .lut_cos_addr(lut_cos_addr), .lut_cos_value(lut_cos_value),
        .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    assign lut_sin_value = rom[lut_sin_addr];
    assign lut_cos_value = rom[lut_cos_addr];

    // Amplitude 2047 rounded, capped at 0x7FE as the ROM contract requires.
    function automatic int scaled(real x);
        real a;
        int  m;
        a = (x < 0.0) ? -x * 2047.0 : x * 2047.0;
        m = $rtoi(a + 0.5);
        if (m > 2046) m = 2046;
        return (x < 0.0) ? -m : m;
    endfunction

    function automatic int ref_sin(int i);
        return scaled($sin((i + 0.5) * 2.0 * PI / NPTS));
    endfunction

    function automatic int ref_cos(int i);
        return scaled($cos((i + 0.5) * 2.0 * PI / NPTS));
    endfunction

    // Distance into the quarter, mirrored on quadrants 1 and 3.
    function automatic int ref_addr(int i);
        int q;
        int r;
        q = (i / (NPTS / 4)) % 4;
        r = i % (NPTS / 4);
        return (q % 2 == 0) ? r : (NPTS / 4 - 1 - r);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_acc = '0; m_ftw = '0; m_p = 0; m_vcnt = 0; m_sin = 0; m_cos = 0;
        end else begin
            if (enable) begin
                m_sin = ref_sin(m_p);
                m_cos = ref_cos(m_p);
                m_p   = int'(m_acc[PW-1 -: QD]);
                m_acc = phase_clr ? '0 : m_acc + m_ftw;
                if (m_vcnt < 2) m_vcnt++;
            end
            if (ftw_load) m_ftw = ftw_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", int'(out_valid), (m_vcnt >= 2) ? 1 : 0);
        chk("sin_out", int'(sin_out), m_sin);
        chk("cos_out", int'(cos_out), m_cos);
        chk("sin_addr", int'(lut_sin_addr), ref_addr(m_p));
        chk("cos_addr", int'(lut_cos_addr), ref_addr((m_p + NPTS / 4) % NPTS));
    endtask

    initial begin
        for (int k = 0; k < NPTS / 4; k++)
            rom[k] = DW'(scaled($sin((k + 0.5) * PI / (NPTS / 2))));
        m_acc = '0; m_ftw = '0; m_p = 0; m_vcnt = 0; m_sin = 0; m_cos = 0;

        // reset state, with load/enable asserted to show reset wins
        rst_n = 1'b0; enable = 1'b1; ftw_load = 1'b1; ftw_in = 32'h1234_5678;
        tick(); tick();
        chk("rst_sin", int'(sin_out), 0);
        chk("rst_cos_addr", int'(lut_cos_addr), 63);

        // ftw = 2^24: one index per edge over more than a full period
        rst_n = 1'b1; ftw_in = 32'h0100_0000; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        chk("valid_after_1", int'(out_valid), 0);
        tick();
        chk("first_sin", int'(sin_out), 25);
        chk("first_cos", int'(cos_out), 2046);
        tick(); tick();
        chk("second_sin", int'(sin_out), 75);
        for (int t = 0; t < 300; t++) tick();

        // step doubles one edge after load
        ftw_in = 32'h0200_0000; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        for (int t = 0; t < 20; t++) tick();

        // enable 1,0,0,1 pattern
        ftw_in = 32'h0100_0000; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        for (int t = 0; t < 8; t++) begin
            enable = (t % 4 == 1 || t % 4 == 2) ? 1'b0 : 1'b1;
            tick();
        end
        enable = 1'b1;

        // phase clear with simultaneous ftw load
        while (m_acc[PW-1 -: QD] != 8'd100) tick();
        phase_clr = 1'b1; ftw_load = 1'b1; ftw_in = 32'h0100_0000;
        tick();
        phase_clr = 1'b0; ftw_load = 1'b0;
        tick(); tick();
        chk("clr_sin", int'(sin_out), 25);
        chk("clr_cos", int'(cos_out), 2046);

        // negative tuning word walks backwards through the wrap
        phase_clr = 1'b1; ftw_load = 1'b1; ftw_in = 32'hFF00_0000;
        tick();
        phase_clr = 1'b0; ftw_load = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        chk("neg_sin_255", int'(sin_out), -25);
        tick();
        chk("neg_sin_254", int'(sin_out), -75);
        for (int t = 0; t < 10; t++) tick();

        // mid-run reset
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", int'(out_valid), 0);
        rst_n = 1'b1;

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            enable    = ($urandom_range(0, 3) != 0);
            phase_clr = ($urandom_range(0, 29) == 0);
            ftw_load  = ($urandom_range(0, 9) == 0);
            ftw_in    = $urandom;
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
